// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory arbiter.
// Holds the FSM state enum, port ids, default depth and word shift.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR,
        DONE
    } state_t;

    localparam logic PORT_CORE     = 1'b0;
    localparam logic PORT_AUX      = 1'b1;
    localparam int   DEFAULT_DEPTH = 256;
    localparam int   WORD_SHIFT    = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a registered priority pointer.
// Ports: clk, rst_n, req[1:0], update (advance pointer), gnt[1:0] one-hot.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // ptr names the port that wins a tie.
    logic ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    // After any grant, priority moves to the port that did not win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (update && (|req)) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port data memory between the core LSU and an aux master.
// Ports: req/we/addr/wdata in and ack/err/rdata out per port, mem_* strobes,
// mem_data_out from memory, busy and gnt_id status.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    output logic        err0,
    output logic [31:0] rdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] rdata1,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data_out,
    output logic        busy,
    output logic        gnt_id
);

    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       gnt;
    logic             idle;
    logic             sel;
    logic             sel_we;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic             sel_err;

    assign idle = (state == IDLE);

    // Requests are only looked at while idle, so the pointer only moves then.
    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1, req0}),
        .update (idle),
        .gnt    (gnt)
    );

    assign sel       = gnt[1];
    assign sel_we    = sel ? we1 : we0;
    assign sel_addr  = sel ? addr1 : addr0;
    assign sel_wdata = sel ? wdata1 : wdata0;
    assign sel_err   = (sel_addr[WORD_SHIFT-1:0] != '0)
                    || ((sel_addr >> WORD_SHIFT) >= 32'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            mem_address <= '0;
            mem_data_in <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            busy        <= 1'b0;
            gnt_id      <= 1'b0;
        end else begin
            // ack/err are single-cycle pulses, set only on entry to DONE.
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        gnt_id <= sel;
                        busy   <= 1'b1;
                        if (sel_err) begin
                            // Bad address: skip the memory entirely.
                            state <= DONE;
                            ack0  <= (sel == PORT_CORE);
                            err0  <= (sel == PORT_CORE);
                            ack1  <= (sel == PORT_AUX);
                            err1  <= (sel == PORT_AUX);
                        end else if (sel_we) begin
                            state       <= WR;
                            mem_write   <= 1'b1;
                            mem_address <= sel_addr >> WORD_SHIFT;
                            mem_data_in <= sel_wdata;
                        end else begin
                            state       <= RD_WAIT;
                            mem_read    <= 1'b1;
                            mem_address <= sel_addr >> WORD_SHIFT;
                            cnt         <= '0;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        state    <= DONE;
                        mem_read <= 1'b0;
                        if (gnt_id == PORT_AUX) begin
                            rdata1 <= mem_data_out;
                            ack1   <= 1'b1;
                        end else begin
                            rdata0 <= mem_data_out;
                            ack0   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WR: begin
                    state     <= DONE;
                    mem_write <= 1'b0;
                    if (gnt_id == PORT_AUX) begin
                        ack1 <= 1'b1;
                    end else begin
                        ack0 <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised self-checking bench for data_mem_arbiter.
// A transaction-level model predicts every output on every cycle.
module tb_data_mem_arbiter;

    localparam int DEPTH = 256;
    localparam int L     = 2;
    localparam int NC    = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, err0, ack1, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_read, mem_write, busy, gnt_id;

    data_mem_arbiter #(.DEPTH(DEPTH), .RD_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_data_out(mem_data_out), .busy(busy), .gnt_id(gnt_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    // Stand-in data memory: data is only valid in the last cycle of a
    // RD_LATENCY-long read window.
    logic [31:0] bmem [DEPTH];
    bit          wrote [DEPTH];
    int          rd_run;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_run <= 0;
        else rd_run <= mem_read ? rd_run + 1 : 0;
    end

    always @(posedge clk) begin
        if (mem_write && mem_address < 32'(DEPTH)) begin
            bmem[mem_address[7:0]]  <= mem_data_in;
            wrote[mem_address[7:0]] <= 1'b1;
        end
    end

    always_comb begin
        mem_data_out = 32'h0BAD_F00D;
        if (mem_read && rd_run == L - 1 && mem_address < 32'(DEPTH))
            mem_data_out = wrote[mem_address[7:0]] ? bmem[mem_address[7:0]]
                                                   : init_val(int'(mem_address));
    end

    typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
    typedef struct { int port; int cyc; bit err; logic [31:0] rdata; } ack_t;

    txn_t q0[$], q1[$];
    ack_t alog[$];
    bit   active[2];
    int   start_pct, hold_pct;

    // Per-cycle expectations, filled when the model grants a request.
    bit          e_busy[NC], e_rd[NC], e_wr[NC];
    bit          e_ack0[NC], e_ack1[NC], e_err0[NC], e_err1[NC];
    logic [31:0] e_addr[NC], e_wd[NC];
    logic [31:0] ref_mem[DEPTH];
    int          ptr_m, gnt_m, next_sample;
    logic [31:0] rd_m[2], pval[2];
    bit          pv[2];
    int          pc[2];

    int checks, errors, k, k0, log0;
    int ph_rd, ph_wr, ph_win;
    bit prev_rd;
    logic [31:0] last_wr_addr;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, k, a, e);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic check_cycle();
        for (int p = 0; p < 2; p++)
            if (pv[p] && pc[p] == k) begin
                rd_m[p] = pval[p];
                pv[p] = 1'b0;
            end
        chk("ack0", 32'(ack0), 32'(e_ack0[k]));
        chk("ack1", 32'(ack1), 32'(e_ack1[k]));
        chk("err0", 32'(err0), 32'(e_err0[k]));
        chk("err1", 32'(err1), 32'(e_err1[k]));
        chk("rdata0", rdata0, rd_m[0]);
        chk("rdata1", rdata1, rd_m[1]);
        chk("mem_read", 32'(mem_read), 32'(e_rd[k]));
        chk("mem_write", 32'(mem_write), 32'(e_wr[k]));
        chk("busy", 32'(busy), 32'(e_busy[k]));
        chk("gnt_id", 32'(gnt_id), 32'(gnt_m));
        if (e_rd[k] || e_wr[k]) chk("mem_address", mem_address, e_addr[k]);
        if (e_wr[k]) chk("mem_data_in", mem_data_in, e_wd[k]);
    endtask

    task automatic present(input int p);
        active[p] = 1'b1;
        if (p == 0) begin
            req0 = 1'b1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata;
        end else begin
            req1 = 1'b1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata;
        end
    endtask

    task automatic drive();
        if (active[0] && ack0) begin
            q0.delete(0);
            active[0] = 1'b0;
            if (q0.size() > 0 && $urandom_range(99) < 32'(hold_pct)) present(0);
            else req0 = 1'b0;
        end else if (!active[0] && q0.size() > 0 && $urandom_range(99) < 32'(start_pct)) begin
            present(0);
        end
        if (active[1] && ack1) begin
            q1.delete(0);
            active[1] = 1'b0;
            if (q1.size() > 0 && $urandom_range(99) < 32'(hold_pct)) present(1);
            else req1 = 1'b0;
        end else if (!active[1] && q1.size() > 0 && $urandom_range(99) < 32'(start_pct)) begin
            present(1);
        end
    endtask

    // Transaction view: a grant at sample cycle t finishes at t+lat, where
    // lat is 1 (bad address), 2 (store) or L+1 (load).
    task automatic model_sample();
        int w, lat, t;
        bit r0, r1, we, bad;
        logic [31:0] a, wd, idx;
        t = k; r0 = req0; r1 = req1;
        if (!rst_n || t < next_sample || !(r0 || r1)) return;
        if (r0 && r1) w = ptr_m;
        else w = r1 ? 1 : 0;
        ptr_m = 1 - w;
        if (w == 0) begin we = we0; a = addr0; wd = wdata0; end
        else begin we = we1; a = addr1; wd = wdata1; end
        idx = a / 4;
        bad = (a % 4 != 0) || (idx >= 32'(DEPTH));
        lat = bad ? 1 : (we ? 2 : L + 1);
        for (int c = t + 1; c <= t + lat; c++) e_busy[c] = 1'b1;
        if (w == 0) begin e_ack0[t+lat] = 1'b1; e_err0[t+lat] = bad; end
        else begin e_ack1[t+lat] = 1'b1; e_err1[t+lat] = bad; end
        if (!bad && we) begin
            e_wr[t+1] = 1'b1; e_addr[t+1] = idx; e_wd[t+1] = wd;
            ref_mem[idx[7:0]] = wd;
        end
        if (!bad && !we) begin
            for (int c = t + 1; c <= t + L; c++) begin
                e_rd[c] = 1'b1; e_addr[c] = idx;
            end
            pv[w] = 1'b1; pc[w] = t + lat; pval[w] = ref_mem[idx[7:0]];
        end
        gnt_m = w;
        next_sample = t + lat + 1;
    endtask

    task automatic step();
        @(negedge clk);
        k++;
        if (k >= NC - 16) begin
            checks++; errors++;
            $display("FAIL cycle_budget cycle %0d: got no end of run, expected < %0d", k, NC - 16);
            finish_sim();
        end
        check_cycle();
        if (ack0) alog.push_back('{0, k, err0, rdata0});
        if (ack1) alog.push_back('{1, k, err1, rdata1});
        if (mem_write) begin ph_wr++; last_wr_addr = mem_address; end
        if (mem_read) ph_rd++;
        if (mem_read && !prev_rd) ph_win++;
        prev_rd = mem_read;
        drive();
        model_sample();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q0.size() > 0 || q1.size() > 0 || active[0] || active[1] || k < next_sample) begin
            step();
            n++;
            if (n > budget) begin
                checks++; errors++;
                $display("FAIL drain_timeout cycle %0d: got %0d/%0d queued, expected 0/0",
                         k, q0.size(), q1.size());
                finish_sim();
            end
        end
        step();
        step();
    endtask

    task automatic begin_phase(input int sp, input int hp);
        start_pct = sp; hold_pct = hp;
        k0 = k + 1; log0 = alog.size();
        ph_rd = 0; ph_wr = 0; ph_win = 0;
    endtask

    function automatic txn_t rnd_txn();
        txn_t t;
        int r = int'($urandom_range(9));
        t.we = 1'($urandom_range(1));
        t.wdata = $urandom;
        if (r <= 5) t.addr = 32'($urandom_range(255)) * 4;
        else if (r == 6) t.addr = 32'($urandom_range(255)) * 4 + 32'($urandom_range(3, 1));
        else if (r == 7) t.addr = ($urandom | 32'h400) & 32'hFFFF_FFFC;
        else if (r == 8) t.addr = 32'h3FC;
        else t.addr = 32'h400;
        return t;
    endfunction

    initial begin
        int sp[3] = '{100, 50, 20};
        int hp[3] = '{100, 50, 0};
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        checks = 0; errors = 0; k = 0; next_sample = 0;
        ptr_m = 0; gnt_m = 0; rd_m[0] = 0; rd_m[1] = 0;
        prev_rd = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);

        #1;
        chk("reset_ack0", 32'(ack0), 0);
        chk("reset_ack1", 32'(ack1), 0);
        chk("reset_rdata0", rdata0, 0);
        chk("reset_rdata1", rdata1, 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_gnt_id", 32'(gnt_id), 0);
        chk("reset_mem_rw", {30'b0, mem_read, mem_write}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous loads, both held: port 0 first, then alternating.
        begin_phase(100, 100);
        q0.push_back('{1'b0, 32'h20, 32'h0}); q0.push_back('{1'b0, 32'h24, 32'h0});
        q0.push_back('{1'b0, 32'h28, 32'h0});
        q1.push_back('{1'b0, 32'h40, 32'h0}); q1.push_back('{1'b0, 32'h44, 32'h0});
        q1.push_back('{1'b0, 32'h48, 32'h0});
        drain(200);
        chk("rr_acks", alog.size() - log0, 6);
        if (alog.size() - log0 == 6) begin
            chk("rr_first_lat", alog[log0].cyc - k0, 3);
            chk("rr_second_lat", alog[log0+1].cyc - k0, 7);
            for (int i = 0; i < 6; i++) chk("rr_order", alog[log0+i].port, i % 2);
        end

        // Store then load on port 0.
        begin_phase(100, 100);
        q0.push_back('{1'b1, 32'h10, 32'hDEAD_BEEF});
        q0.push_back('{1'b0, 32'h10, 32'h0});
        drain(200);
        chk("sl_wr_cycles", ph_wr, 1);
        chk("sl_wr_addr", last_wr_addr, 4);
        chk("sl_acks", alog.size() - log0, 2);
        if (alog.size() - log0 == 2) begin
            chk("sl_store_lat", alog[log0].cyc - k0, 2);
            chk("sl_load_lat", alog[log0+1].cyc - k0, 6);
            chk("sl_rdata", alog[log0+1].rdata, 32'hDEAD_BEEF);
            chk("sl_err", 32'(alog[log0+1].err), 0);
        end

        // Port 1 misaligned then out-of-range.
        begin_phase(100, 100);
        q1.push_back('{1'b0, 32'h6, 32'h0});
        q1.push_back('{1'b0, 32'h400, 32'h0});
        drain(200);
        chk("er_strobes", ph_rd + ph_wr, 0);
        chk("er_acks", alog.size() - log0, 2);
        if (alog.size() - log0 == 2) begin
            chk("er_lat0", alog[log0].cyc - k0, 1);
            chk("er_lat1", alog[log0+1].cyc - k0, 3);
            chk("er_err", {30'b0, alog[log0].err, alog[log0+1].err}, 3);
        end

        // Reset in the middle of RD_WAIT.
        begin_phase(100, 100);
        q0.push_back('{1'b0, 32'h30, 32'h0});
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_mem_read", 32'(mem_read), 0);
        chk("rst_busy", 32'(busy), 0);
        ptr_m = 0; gnt_m = 0; rd_m[0] = 0; rd_m[1] = 0; pv[0] = 0; pv[1] = 0;
        for (int c = k + 1; c <= k + 10; c++) begin
            e_busy[c] = 0; e_rd[c] = 0; e_wr[c] = 0;
            e_ack0[c] = 0; e_ack1[c] = 0; e_err0[c] = 0; e_err1[c] = 0;
        end
        next_sample = NC;
        q0.delete(); q1.delete();
        active[0] = 0; active[1] = 0; req0 = 0; req1 = 0;
        step();
        step();
        rst_n = 1'b1;
        next_sample = k + 1;
        step();
        chk("rst_no_ack", alog.size() - log0, 0);
        begin_phase(100, 0);
        q0.push_back('{1'b0, 32'h34, 32'h0});
        q1.push_back('{1'b0, 32'h38, 32'h0});
        drain(200);
        chk("rst_ptr_acks", alog.size() - log0, 2);
        if (alog.size() - log0 == 2) chk("rst_ptr_port0", alog[log0].port, 0);

        // Port 1 holds req after ack: two read windows.
        begin_phase(100, 100);
        q1.push_back('{1'b0, 32'h50, 32'h0});
        q1.push_back('{1'b0, 32'h54, 32'h0});
        drain(200);
        chk("hold_windows", ph_win, 2);
        chk("hold_rd_cycles", ph_rd, 4);

        // Last word store/load.
        begin_phase(100, 100);
        q0.push_back('{1'b1, 32'h3FC, 32'h1234_5678});
        q0.push_back('{1'b0, 32'h3FC, 32'h0});
        drain(200);
        chk("last_acks", alog.size() - log0, 2);
        if (alog.size() - log0 == 2) begin
            chk("last_err", {30'b0, alog[log0].err, alog[log0+1].err}, 0);
            chk("last_rdata", alog[log0+1].rdata, 32'h1234_5678);
        end

        // Random traffic at several request densities.
        for (int r = 0; r < 3; r++) begin
            begin_phase(sp[r], hp[r]);
            for (int i = 0; i < 50; i++) begin
                q0.push_back(rnd_txn());
                q1.push_back(rnd_txn());
            end
            drain(2000);
        end

        finish_sim();
    end

endmodule
